id_stage: RTL
=============

# id_stage

Registered instruction-decode pipeline stage for the pipelined core. Accepts fetched instructions and PC from IF over a valid/ready handshake and decodes them with the existing `decoder_glue` as a sub-module. Adds illegal-instruction detection, load-use hazard stalling with bubble insertion, and flush. Delivers one registered control/operand bundle per cycle to EX.

## Interface
- `PC_W`, default 32: width of the PC carried with each instruction.
- `HAZARD_EN`, default 1: 1 enables load-use stall logic; 0 ties the stall term to 0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  IF holds a valid instruction.
- `in_ready`  out  1  ID accepts this cycle; transfer occurs when `in_valid && in_ready`.
- `in_instr`  in  32  RV32I instruction word.
- `in_pc`  in  PC_W  PC of `in_instr`.
- `flush`  in  1  kill the ID/EX register content; block acceptance this cycle.
- `ex_load_valid`  in  1  EX currently holds a load.
- `ex_load_rd`  in  5  destination register of that load.
- `out_valid`  out  1  ID/EX register holds a valid instruction.
- `out_ready`  in  1  EX accepts; transfer occurs when `out_valid && out_ready`.
- `out_pc`  out  PC_W  registered PC.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  registered register indices.
- `out_imm`  out  32  registered immediate.
- `out_ctrl`  out  CTRL_W  packed control bundle: reg_write, mem_read, mem_write, alu_src, branch, jump, alu_op[1:0], imm_sel[2:0], wb_sel[1:0], funct3[2:0], funct7b5.
- `out_illegal`  out  1  the registered instruction is illegal.

## Operation
- Operand-use flags, computed combinationally:
  - rs1_used: all opcodes except LUI, AUIPC and JAL.
  - rs2_used: R-type, STORE and BRANCH.
- stall = `HAZARD_EN && ex_load_valid && ex_load_rd != 0 && in_valid`, AND-ed with (`rs1_used && rs1 == ex_load_rd`) OR (`rs2_used && rs2 == ex_load_rd`).
- slot_free = `!out_valid || out_ready`.
- `in_ready = slot_free && !stall && !flush`.
- Next-state of `out_valid` and payload, in priority order:
  1. `flush`: `out_valid` ← 0. Payload holds.
  2. Accept (`in_valid && in_ready`): `out_valid` ← 1. Payload ← decode of `in_instr`/`in_pc`.
  3. slot_free and not accepting (stall or no input): `out_valid` ← 0, which inserts a bubble. Payload holds.
  4. Otherwise (`out_valid && !out_ready`): hold everything.
- Illegal instruction conditions:
  - `instr[1:0] != 2'b11`.
  - Opcode outside {R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE 0001111, SYSTEM 1110011}.
  - JALR with funct3 ≠ 000.
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 011, 110 or 111.
  - STORE with funct3 > 010.
  - R-type with funct7 ∉ {0000000, 0100000}.
  - R-type with funct7 = 0100000 and funct3 ∉ {000, 101}.
- On an illegal instruction: `out_illegal` = 1 and all ctrl bits are forced to 0, so no writeback and no memory access. Indices and imm are still registered.
- FENCE and SYSTEM are legal no-ops: ctrl = 0, `out_illegal` = 0.
- Field slicing, imm generation and base control values come from `decoder_glue` and are not altered for legal opcodes.

## Timing
- Reset values: `out_valid` = 0, `out_pc`/`out_rd`/`out_rs1`/`out_rs2`/`out_imm`/`out_ctrl` = 0, `out_illegal` = 0. `in_ready` is combinational and equals 1 out of reset while `flush` = 0.
- Latency is 1 cycle from input acceptance to `out_valid`.
- Throughput is 1 instruction per cycle when there is no stall and `out_ready` = 1.
- Payload is stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally on `out_ready`, `flush` and the hazard inputs. It must not depend on `in_valid` except through the stall term.
- Simultaneous `flush` and stall: flush wins; the result is `out_valid` = 0.
- Reset asserted mid-transfer clears the register immediately, without waiting for `clk`.

## Structure
- Shared package `id_pkg`:
  - opcode constants (OPC_*), funct3 constants for legality checks.
  - CTRL_W and bit-position constants for `out_ctrl` fields.
- Sub-modules:
  - `decoder_glue`: instantiated unchanged for decode.
  - `id_legal_chk`: one combinational sub-module producing illegal, rs1_used and rs2_used.

## Test plan
- Back-to-back `add x5,x1,x2`, then `addi x6,x1,0x7F`, with `out_ready`=1 → each appears 1 cycle after acceptance, `out_valid` continuous, imm = 0x7F on the second.
- `out_ready`=0 for 3 cycles holding `lw x7,24(x3)` → `out_valid`=1, payload unchanged, `in_ready`=0; the next instruction is accepted the cycle `out_ready` rises.
- `ex_load_valid`=1 with `ex_load_rd`=1, input `add x5,x1,x2` → `in_ready`=0, bubble (`out_valid`=0) for 1 cycle. Drop `ex_load_valid` → accepted next cycle. Repeat with `ex_load_rd`=0 → no stall.
- `flush` during accept of `beq x1,x2,+16` with `out_valid`=1 → `in_ready`=0, next cycle `out_valid`=0. Beq is accepted in the first cycle after `flush` drops.
- Inputs 0x00000000, 0x0000_0073 (ECALL) and `instr[1:0]`=2'b01 → illegal=1 with ctrl=0 for the first and third; ECALL gives illegal=0 with ctrl=0.
- Assert `rst_n`=0 asynchronously while `out_valid`=1 → all outputs zero before the next `clk` edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, funct3/funct7 values
// used by the legality check, and the layout of the packed control bundle.
package id_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 / funct7 values referenced by the legality check
    localparam logic [2:0] F3_JALR     = 3'b000;
    localparam logic [2:0] F3_BR_RSV0  = 3'b010;
    localparam logic [2:0] F3_BR_RSV1  = 3'b011;
    localparam logic [2:0] F3_LD_RSV0  = 3'b011;
    localparam logic [2:0] F3_LD_RSV1  = 3'b110;
    localparam logic [2:0] F3_LD_RSV2  = 3'b111;
    localparam logic [2:0] F3_ST_MAX   = 3'b010;
    localparam logic [2:0] F3_ADD_SUB  = 3'b000;
    localparam logic [2:0] F3_SRL_SRA  = 3'b101;
    localparam logic [6:0] F7_BASE     = 7'b0000000;
    localparam logic [6:0] F7_ALT      = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_BR   = 2'b01,
        ALU_FN   = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // Control bundle; first member is the MSB of out_ctrl
    typedef struct packed {
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     alu_src;
        logic     branch;
        logic     jump;
        alu_op_e  alu_op;
        imm_sel_e imm_sel;
        wb_sel_e  wb_sel;
        logic [2:0] funct3;
        logic     funct7b5;
    } ctrl_t;

    localparam int unsigned CTRL_W = 17;

    // Bit positions of each field inside out_ctrl
    localparam int unsigned CTRL_REG_WRITE = 16;
    localparam int unsigned CTRL_MEM_READ  = 15;
    localparam int unsigned CTRL_MEM_WRITE = 14;
    localparam int unsigned CTRL_ALU_SRC   = 13;
    localparam int unsigned CTRL_BRANCH    = 12;
    localparam int unsigned CTRL_JUMP      = 11;
    localparam int unsigned CTRL_ALU_OP_LO = 9;
    localparam int unsigned CTRL_IMM_SEL_LO = 6;
    localparam int unsigned CTRL_WB_SEL_LO = 4;
    localparam int unsigned CTRL_FUNCT3_LO = 1;
    localparam int unsigned CTRL_FUNCT7B5  = 0;

endpackage

// File: rtl/decoder_glue.sv
// Field slicing, immediate generation and base control decode for RV32I.
// Ports: instr (in, 32) -> rd_c/rs1_c/rs2_c (5 each), imm_c (32), ctrl_c (ctrl_t).
// Unrecognised opcodes produce an all-zero control word.
module decoder_glue
    import id_pkg::*;
(
    input  logic [XLEN-1:0]  instr,
    output logic [REG_W-1:0] rd_c,
    output logic [REG_W-1:0] rs1_c,
    output logic [REG_W-1:0] rs2_c,
    output logic [XLEN-1:0]  imm_c,
    output ctrl_t            ctrl_c
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode = instr[6:0];
    assign rd_c   = instr[11:7];
    assign rs1_c  = instr[19:15];
    assign rs2_c  = instr[24:20];

    // Immediate formats
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Base control per opcode
    always_comb begin
        ctrl_c = '0;
        imm_c  = imm_i;
        case (opcode)
            OPC_OP: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_op    = ALU_FN;
                ctrl_c.funct3    = instr[14:12];
                ctrl_c.funct7b5  = instr[30];
                imm_c            = '0;
            end
            OPC_OP_IMM: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_FN;
                ctrl_c.imm_sel   = IMM_I;
                ctrl_c.funct3    = instr[14:12];
                ctrl_c.funct7b5  = instr[30];
            end
            OPC_LOAD: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.imm_sel   = IMM_I;
                ctrl_c.wb_sel    = WB_MEM;
                ctrl_c.funct3    = instr[14:12];
            end
            OPC_STORE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.imm_sel   = IMM_S;
                ctrl_c.funct3    = instr[14:12];
                imm_c            = imm_s;
            end
            OPC_BRANCH: begin
                ctrl_c.branch    = 1'b1;
                ctrl_c.alu_op    = ALU_BR;
                ctrl_c.imm_sel   = IMM_B;
                ctrl_c.funct3    = instr[14:12];
                imm_c            = imm_b;
            end
            OPC_JAL: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.jump      = 1'b1;
                ctrl_c.imm_sel   = IMM_J;
                ctrl_c.wb_sel    = WB_PC4;
                imm_c            = imm_j;
            end
            OPC_JALR: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.jump      = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.imm_sel   = IMM_I;
                ctrl_c.wb_sel    = WB_PC4;
                ctrl_c.funct3    = instr[14:12];
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_PASS;
                ctrl_c.imm_sel   = IMM_U;
                imm_c            = imm_u;
            end
            default: begin
                ctrl_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_legal_chk.sv
// Combinational RV32I legality check and source-operand usage flags.
// Ports: opcode (7), funct3 (3), funct7 (7) -> illegal_c, rs1_used_c, rs2_used_c.
module id_legal_chk
    import id_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       illegal_c,
    output logic       rs1_used_c,
    output logic       rs2_used_c
);

    always_comb begin
        illegal_c  = 1'b0;
        rs1_used_c = 1'b1;
        rs2_used_c = 1'b0;
        case (opcode)
            OPC_OP: begin
                rs2_used_c = 1'b1;
                // Only the base and alternate (SUB/SRA) encodings exist
                if (funct7 == F7_ALT) begin
                    illegal_c = (funct3 != F3_ADD_SUB) && (funct3 != F3_SRL_SRA);
                end else if (funct7 != F7_BASE) begin
                    illegal_c = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM: begin
                illegal_c = 1'b0;
            end
            OPC_LOAD: begin
                illegal_c = funct3 inside {F3_LD_RSV0, F3_LD_RSV1, F3_LD_RSV2};
            end
            OPC_STORE: begin
                rs2_used_c = 1'b1;
                illegal_c  = funct3 > F3_ST_MAX;
            end
            OPC_BRANCH: begin
                rs2_used_c = 1'b1;
                illegal_c  = funct3 inside {F3_BR_RSV0, F3_BR_RSV1};
            end
            OPC_JALR: begin
                illegal_c = funct3 != F3_JALR;
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: begin
                rs1_used_c = 1'b0;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
        // 16-bit compressed encodings are not supported
        if (opcode[1:0] != 2'b11) begin
            illegal_c = 1'b1;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Registered instruction-decode stage between IF and EX.
// Ports: clk, rst_n; IF side in_valid/in_ready/in_instr/in_pc; flush;
// load-use hazard inputs ex_load_valid/ex_load_rd; EX side out_valid/out_ready
// and registered payload out_pc/out_rd/out_rs1/out_rs2/out_imm/out_ctrl/out_illegal.
// in_ready is combinational; everything else toward EX is registered.
module id_stage
    import id_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              ex_load_valid,
    input  logic [REG_W-1:0]  ex_load_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [XLEN-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal
);

    logic [REG_W-1:0] dec_rd;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic [XLEN-1:0]  dec_imm;
    ctrl_t            dec_ctrl;
    logic             illegal_c;
    logic             rs1_used_c;
    logic             rs2_used_c;

    logic             stall_c;
    logic             slot_free_c;
    logic             accept_c;

    logic             valid_q,   valid_d;
    logic [PC_W-1:0]  pc_q,      pc_d;
    logic [REG_W-1:0] rd_q,      rd_d;
    logic [REG_W-1:0] rs1_q,     rs1_d;
    logic [REG_W-1:0] rs2_q,     rs2_d;
    logic [XLEN-1:0]  imm_q,     imm_d;
    ctrl_t            ctrl_q,    ctrl_d;
    logic             illegal_q, illegal_d;

    decoder_glue u_dec (
        .instr  (in_instr),
        .rd_c   (dec_rd),
        .rs1_c  (dec_rs1),
        .rs2_c  (dec_rs2),
        .imm_c  (dec_imm),
        .ctrl_c (dec_ctrl)
    );

    id_legal_chk u_legal (
        .opcode     (in_instr[6:0]),
        .funct3     (in_instr[14:12]),
        .funct7     (in_instr[31:25]),
        .illegal_c  (illegal_c),
        .rs1_used_c (rs1_used_c),
        .rs2_used_c (rs2_used_c)
    );

    // Load-use hazard: the instruction in ID reads the register a load in EX writes
    always_comb begin
        stall_c = 1'b0;
        if (HAZARD_EN && ex_load_valid && (ex_load_rd != '0) && in_valid) begin
            stall_c = (rs1_used_c && (dec_rs1 == ex_load_rd)) ||
                      (rs2_used_c && (dec_rs2 == ex_load_rd));
        end
    end

    assign slot_free_c = !valid_q || out_ready;
    assign in_ready    = slot_free_c && !stall_c && !flush;
    assign accept_c    = in_valid && in_ready;

    // ID/EX register next state: flush > accept > bubble > hold
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d   = 1'b1;
            pc_d      = in_pc;
            rd_d      = dec_rd;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            imm_d     = dec_imm;
            // An illegal instruction must not write back or touch memory
            ctrl_d    = illegal_c ? ctrl_t'('0) : dec_ctrl;
            illegal_d = illegal_c;
        end else if (slot_free_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rd      = rd_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_imm     = imm_q;
    assign out_ctrl    = ctrl_q;
    assign out_illegal = illegal_q;

endmodule
